// File: rtl/hack_alu_pkg.sv
// Shared definitions for the pipelined Hack ALU: control-bit positions, canonical op encodings, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro consumed by the top: HACK_ALU_MUL_EN (iterative shift-add multiply).
package hack_alu_pkg;

    localparam int CTRL_W = 6;

    // Bit positions inside the {zx,nx,zy,ny,f,no} control word.
    localparam int ZX = 5;
    localparam int NX = 4;
    localparam int ZY = 3;
    localparam int NY = 2;
    localparam int F  = 1;
    localparam int NO = 0;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // The 18 encodings the original Hack CPU emits. Any of the other 46 codes
    // is still decoded faithfully by the core; these names are for readability.
    localparam ctrl_t OP_ZERO      = 6'b101010;
    localparam ctrl_t OP_ONE       = 6'b111111;
    localparam ctrl_t OP_NEG_ONE   = 6'b111010;
    localparam ctrl_t OP_X         = 6'b001100;
    localparam ctrl_t OP_Y         = 6'b110000;
    localparam ctrl_t OP_NOT_X     = 6'b001101;
    localparam ctrl_t OP_NOT_Y     = 6'b110001;
    localparam ctrl_t OP_NEG_X     = 6'b001111;
    localparam ctrl_t OP_NEG_Y     = 6'b110011;
    localparam ctrl_t OP_X_PLUS_1  = 6'b011111;
    localparam ctrl_t OP_Y_PLUS_1  = 6'b110111;
    localparam ctrl_t OP_X_MINUS_1 = 6'b001110;
    localparam ctrl_t OP_Y_MINUS_1 = 6'b110010;
    localparam ctrl_t OP_ADD       = 6'b000010;
    localparam ctrl_t OP_SUB_XY    = 6'b010011;
    localparam ctrl_t OP_SUB_YX    = 6'b000111;
    localparam ctrl_t OP_AND       = 6'b000000;
    localparam ctrl_t OP_OR        = 6'b010101;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    // True when the control word is one of the 18 canonical Hack encodings.
    // Handy for decode-stage assertions or statistics counters.
    function automatic logic is_canonical_op(input ctrl_t c);
        logic hit;
        hit = 1'b0;
        case (c)
            OP_ZERO, OP_ONE, OP_NEG_ONE, OP_X, OP_Y, OP_NOT_X, OP_NOT_Y,
            OP_NEG_X, OP_NEG_Y, OP_X_PLUS_1, OP_Y_PLUS_1, OP_X_MINUS_1,
            OP_Y_MINUS_1, OP_ADD, OP_SUB_XY, OP_SUB_YX, OP_AND, OP_OR: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/hack_alu_core.sv
// Combinational Hack ALU datapath: r = no(f ? x+y : x&y) with zx/nx/zy/ny operand preconditioning.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller registers the result.
// Ports: a, b (WIDTH-bit operands), ctrl ({zx,nx,zy,ny,f,no}), r (WIDTH-bit result, modulo 2^WIDTH).
module hack_alu_core
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [WIDTH-1:0]  r
);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] fx;

    always_comb begin
        x  = ctrl[ZX] ? '0 : a;
        x  = ctrl[NX] ? ~x : x;
        y  = ctrl[ZY] ? '0 : b;
        y  = ctrl[NY] ? ~y : y;
        // Carry out of the adder is dropped: arithmetic is modulo 2^WIDTH.
        fx = ctrl[F] ? (x + y) : (x & y);
        r  = ctrl[NO] ? ~fx : fx;
    end

endmodule

// File: rtl/hack_alu_pipe.sv
// Registered Hack ALU with valid/ready in and out; optional shift-add multiply (macro HACK_ALU_MUL_EN).
// Latency: ALU 1 cycle; multiply WIDTH+1 cycles (in_ready low while multiplying).
// Backpressure: result register holds while out_valid && !out_ready; in_ready passes out_ready through combinationally.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_a/in_b/in_ctrl/in_mul request side;
//        out_valid/out_ready/out_data/out_zr/out_ng result side. WIDTH must be >= 2.
module hack_alu_pipe
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_mul,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_zr,
    output logic              out_ng
);

    logic [WIDTH-1:0] alu_r;

    hack_alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a    (in_a),
        .b    (in_b),
        .ctrl (in_ctrl),
        .r    (alu_r)
    );

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             in_fire;
    logic             mul_req;

    // The output slot is free either when empty or when it drains this cycle,
    // which lets a new ALU result replace the old one with no bubble.
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;

`ifdef HACK_ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_step;

    assign mul_req = in_mul;
`else
    // Multiply compiled out: the port stays for a stable interface but is inert.
    logic unused_in_mul;
    assign unused_in_mul = in_mul;
    assign mul_req       = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        // A held result stays; a consumed one clears unless reloaded below.
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
`ifdef HACK_ALU_MUL_EN
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        // Only the low WIDTH bits of the product are kept, so the accumulator
        // and shifted multiplicand never need to be wider than WIDTH.
        acc_step    = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

        case (state_q)
            IDLE: begin
                if (in_fire && !mul_req) begin
                    out_valid_d = 1'b1;
                    out_data_d  = alu_r;
                end
`ifdef HACK_ALU_MUL_EN
                if (in_fire && mul_req) begin
                    mcand_d  = in_a;
                    mplier_d = in_b;
                    acc_d    = '0;
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = MUL;
                end
`endif
            end
`ifdef HACK_ALU_MUL_EN
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                // The final partial product is folded in on the same edge the
                // counter hits zero, so the result appears WIDTH edges after
                // acceptance. The slot is guaranteed empty: in_ready required it.
                if (cnt_q == CNT_W'(1)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_step;
                    state_d     = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef HACK_ALU_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end
`endif

    // Flags derive from the registered result so they can never disagree with it.
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_zr    = (out_data_q == '0);
    assign out_ng    = out_data_q[WIDTH-1];

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Self-checking bench for hack_alu_pipe (WIDTH = 16) with directed vectors and a full control sweep.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Multiply scenarios run when HACK_ALU_MUL_EN is defined; otherwise in_mul must be ignored.
module tb_hack_alu_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [5:0]   in_ctrl = '0;
    logic         in_mul = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_zr;
    logic         out_ng;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hack_alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ctrl   (in_ctrl),
        .in_mul    (in_mul),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zr    (out_zr),
        .out_ng    (out_ng)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Reference model of the Hack datapath equations.
    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [5:0] c);
        logic [W-1:0] x, y, r;
        x = a;
        if (c[5]) x = '0;
        if (c[4]) x = ~x;
        y = b;
        if (c[3]) y = '0;
        if (c[2]) y = ~y;
        if (c[1]) r = W'(x + y);
        else      r = x & y;
        if (c[0]) r = ~r;
        return r;
    endfunction

    // Present a request and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] c,
                        input logic mul, output bit ok);
        in_a = a; in_b = b; in_ctrl = c; in_mul = mul; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mul   = 1'b0;
    endtask

    // Count falling edges until out_valid; captures the result and whether in_ready was seen high meanwhile.
    task automatic wait_result(input int max_cyc, output bit ok, output int cyc,
                               output logic [W-1:0] d, output logic zr, output logic ng,
                               output logic rdy_seen);
        ok = 1'b0; cyc = 0; d = 'x; zr = 1'bx; ng = 1'bx; rdy_seen = 1'b0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1; cyc = i; d = out_data; zr = out_zr; ng = out_ng;
                break;
            end
            if (in_ready) rdy_seen = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bit ok;
        rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        #12;
        checks++;
        if ({out_valid, out_data, out_zr, out_ng} !== {1'b0, 16'h0000, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_initial: got v=%b d=%h zr=%b ng=%b, want v=0 d=0000 zr=1 ng=0",
                     out_valid, out_data, out_zr, out_ng);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        // Leave an unconsumed negative result in the slot, then reset mid-stream.
        out_ready = 1'b0;
        send(16'd3, 16'd5, 6'b010011, 1'b0, ok);
        @(negedge clk);
        checks++;
        if (!ok || out_valid !== 1'b1 || out_data !== 16'hFFFE) begin
            failures++;
            $display("FAIL reset_preload: ok=%0d v=%b d=%h want ok=1 v=1 d=fffe", ok, out_valid, out_data);
        end
        #2; rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_zr, out_ng} !== {1'b0, 16'h0000, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_midstream: got v=%b d=%h zr=%b ng=%b, want v=0 d=0000 zr=1 ng=0",
                     out_valid, out_data, out_zr, out_ng);
        end
        @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b v=%b want in_ready=1 v=0", in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu_vectors;
        logic [5:0]   vc [4] = '{6'b000010, 6'b010011, 6'b101010, 6'b111111};
        logic [W-1:0] vd [4] = '{16'h0008, 16'hFFFE, 16'h0000, 16'h0001};
        logic         vz [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic         vn [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        bit ok, rok;
        int cyc;
        logic [W-1:0] d;
        logic zr, ng, rs;
        for (int i = 0; i < 4; i++) begin
            send(16'd3, 16'd5, vc[i], 1'b0, ok);
            wait_result(5, rok, cyc, d, zr, ng, rs);
            checks++;
            if (!ok || !rok || cyc != 1) begin
                failures++;
                $display("FAIL alu_latency ctrl=%b: accepted=%0d seen=%0d cycles=%0d want 1", vc[i], ok, rok, cyc);
            end
            checks++;
            if (d !== vd[i]) begin
                failures++;
                $display("FAIL alu_data ctrl=%b: got %h want %h", vc[i], d, vd[i]);
            end
            checks++;
            if (zr !== vz[i] || ng !== vn[i]) begin
                failures++;
                $display("FAIL alu_flags ctrl=%b: got zr=%b ng=%b want zr=%b ng=%b", vc[i], zr, ng, vz[i], vn[i]);
            end
        end
    endtask

    task automatic test_sweep;
        bit ok, rok;
        int cyc;
        logic [W-1:0] a, b, d, exp;
        logic zr, ng, rs;
        for (int c = 0; c < 64; c++) begin
            a = W'($urandom);
            b = W'($urandom);
            exp = ref_alu(a, b, 6'(c));
            send(a, b, 6'(c), 1'b0, ok);
            wait_result(5, rok, cyc, d, zr, ng, rs);
            checks++;
            if (!ok || !rok || d !== exp || zr !== (exp == '0) || ng !== exp[W-1]) begin
                failures++;
                $display("FAIL sweep ctrl=%b a=%h b=%h: got d=%h zr=%b ng=%b seen=%0d want d=%h zr=%b ng=%b",
                         6'(c), a, b, d, zr, ng, rok, exp, (exp == '0), exp[W-1]);
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        out_ready = 1'b0;
        send(16'd3, 16'd5, 6'b000010, 1'b0, ok);
        // Second request waits behind the stalled slot.
        in_a = 16'd10; in_b = 16'd4; in_ctrl = 6'b010011; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_data, out_zr, out_ng, in_ready} !== {1'b1, 16'h0008, 1'b0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL backpressure_hold cyc=%0d: got v=%b d=%h zr=%b ng=%b rdy=%b want v=1 d=0008 zr=0 ng=0 rdy=0",
                         k, out_valid, out_data, out_zr, out_ng, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_passthru: in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0006) begin
            failures++;
            $display("FAIL backpressure_next: v=%b d=%h want v=1 d=0006", out_valid, out_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [5:0]   bc [4] = '{6'b000010, 6'b000000, 6'b010101, 6'b000111};
        logic [W-1:0] bd [4] = '{16'h0009, 16'h0002, 16'h0007, 16'hFFFB};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_a = 16'd7; in_b = 16'd2; in_ctrl = bc[i]; in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready op=%0d: in_ready=%b want 1", i, in_ready);
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== bd[i-1]) begin
                    failures++;
                    $display("FAIL b2b_data op=%0d: v=%b d=%h want v=1 d=%h", i - 1, out_valid, out_data, bd[i-1]);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== bd[3]) begin
            failures++;
            $display("FAIL b2b_data op=3: v=%b d=%h want v=1 d=%h", out_valid, out_data, bd[3]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: v=%b want 0", out_valid);
        end
        @(posedge clk); #1;
    endtask

`ifdef HACK_ALU_MUL_EN
    task automatic test_mul;
        bit ok, rok;
        int cyc;
        logic [W-1:0] d;
        logic zr, ng, rs;
        out_ready = 1'b1;
        send(16'd300, 16'd300, 6'b000000, 1'b1, ok);
        wait_result(40, rok, cyc, d, zr, ng, rs);
        checks++;
        if (!ok || !rok || cyc != 17) begin
            failures++;
            $display("FAIL mul_latency: accepted=%0d seen=%0d cycles=%0d want 17", ok, rok, cyc);
        end
        checks++;
        if (d !== 16'h5F90) begin
            failures++;
            $display("FAIL mul_300x300: got %h want 5f90", d);
        end
        checks++;
        if (rs !== 1'b0) begin
            failures++;
            $display("FAIL mul_in_ready: in_ready seen high during multiply, want low");
        end
        send(16'hFFFF, 16'hFFFF, 6'b101010, 1'b1, ok);
        wait_result(40, rok, cyc, d, zr, ng, rs);
        checks++;
        if (!rok || cyc != 17 || d !== 16'h0001 || zr !== 1'b0 || ng !== 1'b0) begin
            failures++;
            $display("FAIL mul_ffff: seen=%0d cycles=%0d d=%h zr=%b ng=%b want 17 0001 zr=0 ng=0",
                     rok, cyc, d, zr, ng);
        end
    endtask

    task automatic test_mul_reset;
        bit ok, rok, seen;
        int cyc;
        logic [W-1:0] d;
        logic zr, ng, rs;
        send(16'd300, 16'd300, 6'b000000, 1'b1, ok);
        repeat (8) @(negedge clk);
        #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL mul_reset_discard: out_valid=1 after reset, want no result");
        end
        @(posedge clk); #1;
        send(16'd3, 16'd5, 6'b000010, 1'b0, ok);
        wait_result(5, rok, cyc, d, zr, ng, rs);
        checks++;
        if (!ok || !rok || cyc != 1 || d !== 16'h0008) begin
            failures++;
            $display("FAIL mul_reset_next_alu: accepted=%0d seen=%0d cycles=%0d d=%h want 1 cycle d=0008",
                     ok, rok, cyc, d);
        end
    endtask
`else
    task automatic test_mul_ignored;
        bit ok, rok;
        int cyc;
        logic [W-1:0] d;
        logic zr, ng, rs;
        out_ready = 1'b1;
        send(16'd3, 16'd5, 6'b000010, 1'b1, ok);
        wait_result(40, rok, cyc, d, zr, ng, rs);
        checks++;
        if (!ok || !rok || cyc != 1 || d !== 16'h0008) begin
            failures++;
            $display("FAIL mul_ignored: accepted=%0d seen=%0d cycles=%0d d=%h want 1 cycle d=0008",
                     ok, rok, cyc, d);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu_vectors();
        test_sweep();
        test_backpressure();
        test_back_to_back();
`ifdef HACK_ALU_MUL_EN
        test_mul();
        test_mul_reset();
`else
        test_mul_ignored();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
